// File: rtl/imem_burst_server_if.sv
// Line-fill bus between the instruction cache (master) and the burst
// server (slave), plus the side write port used for boot/preload.
interface imem_burst_server_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_val;
    logic        busy;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output mem_req, mem_addr, wr_en, wr_addr, wr_data,
        input  mem_data, mem_val, busy
    );

    modport slave (
        input  mem_req, mem_addr, wr_en, wr_addr, wr_data,
        output mem_data, mem_val, busy
    );
endinterface

// File: rtl/imem_burst_server.sv
// Instruction-memory burst server: accepts a line-aligned fill request,
// waits LATENCY cycles, then streams the 8-word line lowest word first.
// Optional feature macro IMEM_BUBBLE_EN inserts one idle cycle after every
// beat but the last, so a line spans 15 cycles instead of 8.
module imem_burst_server #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 3,
    parameter int BLOCK_SIZE  = 8
) (
    input logic              clk,
    input logic              reset,
    imem_burst_server_if.slave bus
);

    localparam int           AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]   LAT      = 4'(LATENCY);
    localparam logic [2:0]   LAST_IDX = 3'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t        state, state_nxt;
    logic [26:0]   base;
    logic [3:0]    lat_cnt;
    logic [2:0]    idx;
    logic          beat_fire;
    logic          busy_c;
    logic [29:0]   word;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          gap;
    logic          mem_val_q;
    logic [31:0]   mem_data_q;
    logic          unused_bits;

    logic [31:0]   mem [DEPTH_WORDS];

    // Word index is the byte address >> 2, taken modulo the array depth.
    assign word   = {base, idx};
    assign rd_idx = word[AW-1:0];
    assign wr_idx = bus.wr_addr[AW+1:2];

    // Low line-offset bits and any index bits above the array depth are
    // deliberately discarded (addresses simply wrap).
    assign unused_bits = ^{bus.mem_addr, bus.wr_addr, word};

`ifdef IMEM_BUBBLE_EN
    // Alternate beat / idle cycle while streaming; restart on a beat phase.
    always_ff @(posedge clk) begin
        if (reset)
            gap <= 1'b0;
        else if (state != BURST)
            gap <= 1'b0;
        else if (bus.mem_req)
            gap <= ~gap;
    end
`else
    assign gap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a dropped request in WAIT/BURST aborts the fill.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.mem_req) state_nxt = (LAT == 4'd0) ? BURST : WAIT;
            WAIT:  if (!bus.mem_req)         state_nxt = IDLE;
                   else if (lat_cnt <= 4'd1) state_nxt = BURST;
            BURST: if (!bus.mem_req)         state_nxt = IDLE;
                   else if (beat_fire && idx == LAST_IDX) state_nxt = DONE;
            DONE:  if (!bus.mem_req)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the per-cycle beat strobe.
    always_comb begin
        busy_c    = (state != IDLE);
        beat_fire = (state == BURST) && bus.mem_req && !gap;
    end

    // Line base, latency counter and beat index.
    always_ff @(posedge clk) begin
        if (reset) begin
            base    <= '0;
            lat_cnt <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.mem_req) begin
                    base    <= bus.mem_addr[31:5];
                    lat_cnt <= LAT;
                    idx     <= '0;
                end
                WAIT: if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                BURST: if (beat_fire) idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end

    // Side write port, active in every state; array is never cleared.
    always_ff @(posedge clk) begin
        if (bus.wr_en)
            mem[wr_idx] <= bus.wr_data;
    end

    // Registered beat outputs; the read sees pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_val_q  <= 1'b0;
            mem_data_q <= '0;
        end else begin
            mem_val_q <= beat_fire;
            if (beat_fire)
                mem_data_q <= mem[rd_idx];
        end
    end

    assign bus.mem_val  = mem_val_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_imem_burst_server.sv
// Randomized scoreboard bench for imem_burst_server: two instances (deep
// array with latency 3, 64-word array with latency 0) against a word-array
// reference model; monitors check beat data and beat cycle.
module tb_imem_burst_server;

    localparam int DEP [2] = '{4096, 64};
    localparam int LATS[2] = '{3, 0};
`ifdef IMEM_BUBBLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;

    logic        req  [2];
    logic [31:0] addr [2];
    logic        wen  [2];
    logic [31:0] waddr[2];
    logic [31:0] wdata[2];

    logic [31:0] refm [2][4096];
    exp_t        q0[$], q1[$];
    exp_t        e0, e1;

    imem_burst_server_if if0();
    imem_burst_server_if if1();

    assign if0.mem_req = req[0];  assign if1.mem_req = req[1];
    assign if0.mem_addr = addr[0]; assign if1.mem_addr = addr[1];
    assign if0.wr_en = wen[0];    assign if1.wr_en = wen[1];
    assign if0.wr_addr = waddr[0]; assign if1.wr_addr = waddr[1];
    assign if0.wr_data = wdata[0]; assign if1.wr_data = wdata[1];

    imem_burst_server #(.DEPTH_WORDS(4096), .LATENCY(3), .BLOCK_SIZE(8)) dut0 (
        .clk(clk), .reset(rst), .bus(if0.slave));
    imem_burst_server #(.DEPTH_WORDS(64), .LATENCY(0), .BLOCK_SIZE(8)) dut1 (
        .clk(clk), .reset(rst), .bus(if1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor for instance 0: every beat must match the head of the queue.
    always @(negedge clk) begin
        if (if0.mem_val === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected beat", 1'b0, if0.mem_data, 32'h0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 beat data", if0.mem_data === e0.data, if0.mem_data, e0.data);
                check("dut0 beat cycle", cyc == e0.cyc, cyc, e0.cyc);
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin
        if (if1.mem_val === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected beat", 1'b0, if1.mem_data, 32'h0);
            end else begin
                e1 = q1.pop_front();
                check("dut1 beat data", if1.mem_data === e1.data, if1.mem_data, e1.data);
                check("dut1 beat cycle", cyc == e1.cyc, cyc, e1.cyc);
            end
        end
    end

    function automatic logic busy_of(input int d);
        return (d == 0) ? if0.busy : if1.busy;
    endfunction

    function automatic logic val_of(input int d);
        return (d == 0) ? if0.mem_val : if1.mem_val;
    endfunction

    function automatic logic [31:0] data_of(input int d);
        return (d == 0) ? if0.mem_data : if1.mem_data;
    endfunction

    // Side-port single word write (called at a negedge, returns at a negedge).
    task automatic side_write(input int d, input int widx, input logic [31:0] v);
        wen[d] = 1'b1; waddr[d] = 32'(widx * 4) | 32'($urandom_range(0, 3)); wdata[d] = v;
        refm[d][widx] = v;
        @(negedge clk);
        wen[d] = 1'b0;
    endtask

    // One fill. kind: 0 = complete, 1 = abort after beat stop_k,
    // 2 = reset after beat stop_k. wbeat >= 0 collides a side write with that beat.
    task automatic fill(input int d, input logic [31:0] a, input int kind,
                        input int stop_k, input int wbeat, input int widx,
                        input logic [31:0] wval);
        int t0, nb, last, n;
        int unsigned w;
        exp_t e;
        t0 = cyc + 1;
        req[d] = 1'b1; addr[d] = a;
        nb = (kind != 0) ? stop_k + 1 : 8;
        for (int k = 0; k < nb; k++) begin
            w = ((int'(a >> 5) * 8) + k) % DEP[d];
            e.data = refm[d][w];
            e.cyc  = t0 + 1 + LATS[d] + k * STEP;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        last = t0 + 1 + LATS[d] + (nb - 1) * STEP;
        while (cyc < last) begin
            @(negedge clk);
            wen[d] = 1'b0;
            if (cyc == t0) begin
                addr[d] = $urandom;
                check("busy rise", busy_of(d) === 1'b1, busy_of(d), 1);
            end
            if (wbeat >= 0 && cyc == t0 + LATS[d] + wbeat * STEP) begin
                wen[d] = 1'b1; waddr[d] = 32'(widx * 4); wdata[d] = wval;
                refm[d][widx] = wval;
            end
        end
        wen[d] = 1'b0;
        if (kind == 1) begin
            req[d] = 1'b0;
            @(negedge clk);
            check("abort busy", busy_of(d) === 1'b0, busy_of(d), 0);
            check("abort val", val_of(d) === 1'b0, val_of(d), 0);
        end else if (kind == 2) begin
            rst = 1'b1; req[d] = 1'b0;
            @(negedge clk);
            check("reset val", val_of(d) === 1'b0, val_of(d), 0);
            check("reset data", data_of(d) === 32'h0, data_of(d), 0);
            check("reset busy", busy_of(d) === 1'b0, busy_of(d), 0);
            rst = 1'b0;
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
            req[d] = 1'b0;
            n = 0;
            while (busy_of(d) !== 1'b0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("busy release", busy_of(d) === 1'b0, busy_of(d), 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; addr[d] = '0; wen[d] = 1'b0; waddr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst val0", if0.mem_val === 1'b0, if0.mem_val, 0);
        check("rst data0", if0.mem_data === 32'h0, if0.mem_data, 0);
        check("rst busy0", if0.busy === 1'b0, if0.busy, 0);
        check("rst val1", if1.mem_val === 1'b0, if1.mem_val, 0);
        check("rst busy1", if1.busy === 1'b0, if1.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill both arrays with random contents so every read is defined.
        for (int i = 0; i < 4096; i++) begin
            wen[0] = 1'b1; waddr[0] = 32'(i * 4); wdata[0] = $urandom;
            refm[0][i] = wdata[0];
            wen[1] = (i < 64);
            if (i < 64) begin
                waddr[1] = 32'(i * 4) | 32'($urandom_range(0, 3)); wdata[1] = $urandom;
                refm[1][i] = wdata[1];
            end
            @(negedge clk);
        end
        wen[0] = 1'b0; wen[1] = 1'b0;
        for (int i = 0; i < 8; i++) side_write(0, 'h40 + i, 32'hA0 + 32'(i));

        // Directed cases.
        fill(0, 32'h0000_0100, 0, 0, -1, 0, 0);
        fill(0, 32'h0000_011C, 0, 0, -1, 0, 0);
        fill(1, 32'h0000_0100, 0, 0, -1, 0, 0);
        fill(0, 32'h0000_0100, 1, 2, -1, 0, 0);
        repeat (2) @(negedge clk);
        fill(0, 32'h0000_0100, 0, 0, -1, 0, 0);
        fill(0, 32'h0000_0100, 2, 5, -1, 0, 0);
        fill(0, 32'h0000_0100, 0, 0, -1, 0, 0);
        fill(0, 32'h0000_0100, 0, 0, 3, 'h43, 32'hDEAD_BEEF);
        fill(0, 32'h0000_0100, 0, 0, -1, 0, 0);
        fill(1, 32'h0000_0100, 1, 0, -1, 0, 0);

        // Randomized fills on both instances, some aborted mid-stream.
        for (int i = 0; i < 40; i++) begin
            int d, kind;
            d = $urandom_range(0, 1);
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            fill(d, $urandom, kind, $urandom_range(0, 6), -1, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("dut0 queue drained", q0.size() == 0, q0.size(), 0);
        check("dut1 queue drained", q1.size() == 0, q1.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
